// File: rtl/cs10_mib_top.sv
// CS10 top-level control: MIB-bus slave bridged to a small command-bus register file
// that drives the inter-FPGA test-pattern buses, the LED and the error-flag readback.
module cs10_mib_top #(
    parameter logic [3:0]  P_MIB_MSN              = 4'h0,
    parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter logic [31:0] P_ID                   = 32'hC510_0A01
) (
    input  logic        CLK,
    input  logic        i_rst_n,
    input  logic        i_mib_start,
    input  logic        i_mib_rd_wr_n,
    inout  wire  [15:0] mib_dabus,
    output logic        o_mib_slave_ack,
    output logic [70:0] IL07,
    output logic [70:0] IL68,
    output logic [70:0] IL12,
    output logic [70:0] IL34,
    input  logic [3:0]  error_dect_50,
    input  logic [3:0]  error_dect_125,
    output logic        led_check
);

    typedef enum logic [3:0] {
        S_IDLE, S_AP2, S_WD1, S_WD2, S_TURN, S_CMD_WAIT, S_WACK, S_RD1, S_RD2
    } state_t;

    localparam logic [15:0] L_TMO_LAST = 16'(P_CMD_ACK_TIMEOUT_CLKS - 1);

    function automatic logic [70:0] rotl1(input logic [70:0] v);
        return {v[69:0], v[70]};
    endfunction

    function automatic logic [70:0] rotr1(input logic [70:0] v);
        return {v[0], v[70:1]};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rd_wr_n;
    logic [7:0]  r_addr_hi;
    logic [13:0] r_addr_lo;
    logic [15:0] r_wdata_hi;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_rdata_lo;
    logic        r_ack;
    logic        r_drv;
    logic [15:0] r_dout;
    logic        w_ack_nxt;
    logic        w_drv_nxt;
    logic [15:0] w_dout_nxt;
    logic        w_cmd_done;
    logic [31:0] w_rdata;

    logic        w_rf_req;
    logic        w_rf_we;
    logic [17:0] w_rf_offset;
    logic [31:0] w_rf_wdata;
    logic        r_rf_ack;
    logic [31:0] r_rf_rdata;
    logic [31:0] r_scratch;
    logic [1:0]  r_ctrl;
    logic [3:0]  r_e50_s1, r_e50_s2, r_e125_s1, r_e125_s2;
    logic        r_led;
    logic [70:0] r_il07, r_il68, r_il12, r_il34;
    logic [70:0] w_cnt_nxt;

    assign w_rf_offset = {r_addr_hi[3:0], r_addr_lo};
    // The write request is presented during WD2, so the low data half comes straight off the bus.
    assign w_rf_wdata  = {r_wdata_hi, mib_dabus};
    assign w_cmd_done  = r_rf_ack || (r_tmo_cnt == L_TMO_LAST);
    assign w_rdata     = r_rf_ack ? r_rf_rdata : 32'hDEAD_DEAD;

    // FSM state register
    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, command issue and next bus-response values
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_drv_nxt   = 1'b0;
        w_dout_nxt  = 16'h0000;
        w_rf_req    = 1'b0;
        w_rf_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_mib_start) begin
                    w_state_nxt = S_AP2;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_AP2: begin
                if (r_addr_hi[7:4] != P_MIB_MSN) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rd_wr_n) begin
                    w_state_nxt = S_TURN;
                end else begin
                    w_state_nxt = S_WD1;
                end
            end
            S_WD1: w_state_nxt = S_WD2;
            S_WD2: begin
                w_rf_req    = 1'b1;
                w_rf_we     = 1'b1;
                w_state_nxt = S_CMD_WAIT;
            end
            S_TURN: begin
                w_rf_req    = 1'b1;
                w_state_nxt = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                if (!w_cmd_done) begin
                    w_state_nxt = S_CMD_WAIT;
                end else if (r_rd_wr_n) begin
                    w_ack_nxt   = 1'b1;
                    w_drv_nxt   = 1'b1;
                    w_dout_nxt  = w_rdata[31:16];
                    w_state_nxt = S_RD1;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_WACK;
                end
            end
            S_WACK: w_state_nxt = S_IDLE;
            S_RD1: begin
                w_ack_nxt   = 1'b1;
                w_drv_nxt   = 1'b1;
                w_dout_nxt  = r_rdata_lo;
                w_state_nxt = S_RD2;
            end
            S_RD2:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // MIB address/data capture, ack timeout counter and registered bus response
    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_wr_n  <= 1'b1;
            r_addr_hi  <= 8'h00;
            r_addr_lo  <= 14'h0000;
            r_wdata_hi <= 16'h0000;
            r_tmo_cnt  <= 16'h0000;
            r_rdata_lo <= 16'h0000;
            r_ack      <= 1'b0;
            r_drv      <= 1'b0;
            r_dout     <= 16'h0000;
        end else begin
            if (r_state == S_IDLE && i_mib_start) begin
                r_addr_hi <= mib_dabus[7:0];
                r_rd_wr_n <= i_mib_rd_wr_n;
            end
            if (r_state == S_AP2) begin
                r_addr_lo <= mib_dabus[15:2];
            end
            if (r_state == S_WD1) begin
                r_wdata_hi <= mib_dabus;
            end
            if (r_state == S_CMD_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= 16'h0000;
            end
            if (r_state == S_CMD_WAIT && w_cmd_done) begin
                r_rdata_lo <= w_rdata[15:0];
            end
            r_ack  <= w_ack_nxt;
            r_drv  <= w_drv_nxt;
            r_dout <= w_dout_nxt;
        end
    end

    // Register file: acks mapped offsets one clock after the request; unmapped offsets stay silent
    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_ack   <= 1'b0;
            r_rf_rdata <= 32'h0000_0000;
            r_scratch  <= 32'h0000_0000;
            r_ctrl     <= 2'b00;
        end else begin
            r_rf_ack <= 1'b0;
            if (w_rf_req) begin
                case (w_rf_offset)
                    18'd0: begin
                        r_rf_ack   <= 1'b1;
                        r_rf_rdata <= P_ID;
                    end
                    18'd1: begin
                        r_rf_ack   <= 1'b1;
                        r_rf_rdata <= r_scratch;
                        if (w_rf_we) begin
                            r_scratch <= w_rf_wdata;
                        end
                    end
                    18'd2: begin
                        r_rf_ack   <= 1'b1;
                        r_rf_rdata <= {16'h0000, r_e125_s2, r_e50_s2, 6'b000000, r_ctrl};
                        if (w_rf_we) begin
                            r_ctrl <= w_rf_wdata[1:0];
                        end
                    end
                    default: begin
                        r_rf_ack   <= 1'b0;
                        r_rf_rdata <= 32'h0000_0000;
                    end
                endcase
            end
        end
    end

    // Error-flag synchronizers and LED drive
    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e50_s1  <= 4'h0;
            r_e50_s2  <= 4'h0;
            r_e125_s1 <= 4'h0;
            r_e125_s2 <= 4'h0;
            r_led     <= 1'b0;
        end else begin
            r_e50_s1  <= error_dect_50;
            r_e50_s2  <= r_e50_s1;
            r_e125_s1 <= error_dect_125;
            r_e125_s2 <= r_e125_s1;
            r_led     <= r_ctrl[1];
        end
    end

    // IL07 doubles as the pattern counter; the other buses are derived from the same next value.
    assign w_cnt_nxt = r_ctrl[0] ? (r_il07 + 71'd1) : r_il07;

    // Test-pattern registers
    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_il07 <= 71'd0;
            r_il68 <= 71'd0;
            r_il12 <= 71'd0;
            r_il34 <= 71'd0;
        end else begin
            r_il07 <= w_cnt_nxt;
            r_il68 <= ~w_cnt_nxt;
            r_il12 <= rotl1(w_cnt_nxt);
            r_il34 <= rotr1(w_cnt_nxt);
        end
    end

    assign mib_dabus       = r_drv ? r_dout : {16{1'bz}};
    assign o_mib_slave_ack = r_ack;
    assign led_check       = r_led;
    assign IL07            = r_il07;
    assign IL68            = r_il68;
    assign IL12            = r_il12;
    assign IL34            = r_il34;

endmodule

// File: tb/tb_cs10_mib_top.sv
// Directed bench for cs10_mib_top: MIB reads/writes with hand-computed expectations.
// The bus is pulled up, so a released bus reads 16'hFFFF.
module tb_cs10_mib_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rd_wr_n;
    logic        tb_drv;
    logic [15:0] tb_dout;
    wire  [15:0] mib_dabus;
    logic        ack;
    logic [70:0] il07, il68, il12, il34;
    logic [3:0]  e50, e125;
    logic        led;

    int          n_total = 0;
    int          n_bad   = 0;
    int          t_acks, t_lat, t_zbad;
    logic [31:0] t_rdata;
    logic [70:0] s_il07, s_il68, s_il12, s_il34;
    logic [70:0] hold_v;

    always #5 clk = ~clk;

    assign mib_dabus = tb_drv ? tb_dout : {16{1'bz}};
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (mib_dabus[g]);
    end

    cs10_mib_top dut (
        .CLK             (clk),
        .i_rst_n         (rst_n),
        .i_mib_start     (start),
        .i_mib_rd_wr_n   (rd_wr_n),
        .mib_dabus       (mib_dabus),
        .o_mib_slave_ack (ack),
        .IL07            (il07),
        .IL68            (il68),
        .IL12            (il12),
        .IL34            (il34),
        .error_dect_50   (e50),
        .error_dect_125  (e125),
        .led_check       (led)
    );

    task automatic check_val(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic rw, input logic d, input logic [15:0] v);
        @(posedge clk);
        #1;
        start   = s;
        rd_wr_n = rw;
        tb_drv  = d;
        tb_dout = v;
    endtask

    // Samples ncyc clocks; base is the cycle offset from the start strobe of the first sample.
    task automatic watch(input int ncyc, input int base, input bit is_rd);
        t_acks  = 0;
        t_lat   = -1;
        t_zbad  = 0;
        t_rdata = 32'h0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (t_lat >= 0 && base + i == t_lat + 1) begin
                s_il07 = il07;
                s_il68 = il68;
                s_il12 = il12;
                s_il34 = il34;
            end
            if (ack) begin
                if (t_acks == 0) begin
                    t_lat = base + i;
                    t_rdata[31:16] = mib_dabus;
                end else if (t_acks == 1) begin
                    t_rdata[15:0] = mib_dabus;
                end
                t_acks++;
            end
            if (!(is_rd && ack) && mib_dabus !== 16'hFFFF) t_zbad++;
        end
    endtask

    task automatic mib_read(input logic [23:0] addr);
        drive(1'b1, 1'b1, 1'b1, {8'h00, addr[23:16]});
        drive(1'b0, 1'b1, 1'b1, addr[15:0]);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        watch(24, 2, 1'b1);
    endtask

    task automatic mib_write(input logic [23:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b0, 1'b1, {8'h00, addr[23:16]});
        drive(1'b0, 1'b0, 1'b1, addr[15:0]);
        drive(1'b0, 1'b0, 1'b1, data[31:16]);
        drive(1'b0, 1'b0, 1'b1, data[15:0]);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        watch(24, 4, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; rd_wr_n = 1'b1; tb_drv = 1'b0; tb_dout = 16'h0000;
        e50 = 4'h0; e125 = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ack",  71'(ack), 71'd0);
        check_val("rst_bus",  71'(mib_dabus), 71'hFFFF);
        check_val("rst_led",  71'(led), 71'd0);
        check_val("rst_il07", il07, 71'd0);
        check_val("rst_il68", il68, 71'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("idle_il07", il07, 71'd0);
        check_val("idle_il68", il68, {71{1'b1}});

        mib_read(24'h000000);
        check_val("id_data", 71'(t_rdata), 71'(32'hC510_0A01));
        check_val("id_acks", 71'(t_acks), 71'd2);
        check_val("id_lat",  71'(t_lat), 71'd4);
        check_val("id_z",    71'(t_zbad), 71'd0);

        mib_write(24'h000004, 32'h0101_0202);
        check_val("wr_scr_acks", 71'(t_acks), 71'd1);
        check_val("wr_scr_lat",  71'(t_lat), 71'd5);
        check_val("wr_scr_z",    71'(t_zbad), 71'd0);
        mib_read(24'h000004);
        check_val("rd_scr", 71'(t_rdata), 71'(32'h0101_0202));
        mib_read(24'h000008);
        check_val("rd_ctrl0", 71'(t_rdata), 71'd0);

        e50 = 4'hA; e125 = 4'h5;
        mib_write(24'h000008, 32'h0000_0003);
        check_val("ctrl_acks", 71'(t_acks), 71'd1);
        check_val("pat_il07", s_il07, 71'd2);
        check_val("pat_il68", s_il68, ~71'd2);
        check_val("pat_il12", s_il12, 71'd4);
        check_val("pat_il34", s_il34, 71'd1);
        check_val("led_on", 71'(led), 71'd1);
        mib_read(24'h000008);
        check_val("rd_ctrl3", 71'(t_rdata), 71'(32'h0000_5A03));
        mib_write(24'h000008, 32'h0000_0000);
        @(negedge clk);
        hold_v = il07;
        repeat (5) @(negedge clk);
        check_val("pat_hold", il07, hold_v);
        check_val("led_off", 71'(led), 71'd0);

        mib_read(24'h100004);
        check_val("msn_acks", 71'(t_acks), 71'd0);
        check_val("msn_z",    71'(t_zbad), 71'd0);
        mib_read(24'h000004);
        check_val("msn_after", 71'(t_rdata), 71'(32'h0101_0202));
        check_val("msn_after_acks", 71'(t_acks), 71'd2);

        mib_read(24'h000040);
        check_val("um_rd_data", 71'(t_rdata), 71'(32'hDEAD_DEAD));
        check_val("um_rd_acks", 71'(t_acks), 71'd2);
        check_val("um_rd_lat",  71'(t_lat), 71'd19);
        mib_write(24'h000040, 32'hFFFF_FFFF);
        check_val("um_wr_acks", 71'(t_acks), 71'd1);
        check_val("um_wr_lat",  71'(t_lat), 71'd20);
        mib_read(24'h000004);
        check_val("um_wr_scr", 71'(t_rdata), 71'(32'h0101_0202));

        drive(1'b1, 1'b0, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 1'b1, 16'h0004);
        drive(1'b0, 1'b0, 1'b1, 16'h1234);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ack", 71'(ack), 71'd0);
        @(posedge clk); #1; tb_drv = 1'b0;
        @(negedge clk);
        check_val("mid_rst_bus", 71'(mib_dabus), 71'hFFFF);
        @(posedge clk); #1; rst_n = 1'b1;
        watch(8, 0, 1'b0);
        check_val("mid_rst_noack", 71'(t_acks), 71'd0);
        check_val("mid_rst_z",     71'(t_zbad), 71'd0);
        mib_read(24'h000004);
        check_val("mid_rst_scr",  71'(t_rdata), 71'd0);
        check_val("mid_rst_acks", 71'(t_acks), 71'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
